fxyz_sweep_ctrl: RTL and testbench
==================================

# fxyz_sweep_ctrl

Sequencer that exhaustively drives the 3-input function unit (`fxyz`, s = (x | y) & ~z) through all 8 input combinations. It waits a programmable settle time per vector, samples `s`, and assembles an 8-bit truth-table vector for the guia04 exercises. It sits between the bench/top level and the function unit: it drives `x`, `y`, `z` and reads `s`.

## Interface
- `SETTLE`, default 1: cycles each vector is held before sampling. Legal range 1..15.
- `EXPECT`, default 8'h54: expected truth table, bit i = s for {x,y,z} = i. Used only with the checker compiled in.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a sweep. Sampled only in IDLE.
- `x`, `y`, `z` out 1 each: drive the function-unit inputs.
- `s` in 1: function-unit output.
- `busy` out 1: high from the first DRIVE cycle through the last SAMPLE cycle.
- `done` out 1: one-cycle pulse; `truth` is complete.
- `truth` out 8: captured table, bit i = s at vector i.
- `mismatch` out 1: checker result. Tied 0 when the checker is compiled out.

## Operation
- Reset values: state IDLE, index 0, settle count 0, `x`=`y`=`z`=0, `busy`=0, `done`=0, `truth`=8'h00, `mismatch`=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE -> DRIVE when `start`=1. On this transition: index <= 0, `truth` <= 0, `mismatch` <= 0.
- DRIVE:
  - `{x,y,z}` = index (x is the MSB).
  - Settle counter counts SETTLE cycles.
  - DRIVE -> SAMPLE after SETTLE cycles in DRIVE.
- SAMPLE:
  - `truth[index]` <= `s`.
  - If index == 7: -> DONE.
  - Otherwise: index <= index + 1, -> DRIVE.
- The 3-bit index never wraps; the sweep terminates at 7.
- DONE: `done`=1 for exactly one cycle, `busy`=0, `{x,y,z}`=000. Then -> IDLE unconditionally.
- `{x,y,z}` = 000 in IDLE and DONE. In SAMPLE they hold the current index.
- `start` is ignored outside IDLE (no queuing). A `start` held high from DONE begins a new sweep only once IDLE is reached.
- `truth` holds after DONE until the next accepted `start` or `reset`.
- Reset mid-sweep: at the next edge all state and outputs return to reset values. No partial `done`.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Vector k enters DRIVE at cycle 1 + k·(SETTLE+1). Its SAMPLE cycle is (k+1)·(SETTLE+1).
- `done` is high at cycle 8·(SETTLE+1)+1. With SETTLE=1 this is cycle 17.
- `truth` is valid and stable in the `done` cycle.
- Back-to-back sweeps: minimum start-to-start spacing is 8·(SETTLE+1)+2 cycles.
- All outputs are registered. No combinational path from `s` or `start` to any output.

## Configuration
- Macro: `GUIA04_SWEEP_CHECK_EN`.
- Defined:
  - In the DONE cycle, `mismatch` <= (`truth` != EXPECT).
  - Valid from the cycle after `done`.
  - Held until the next accepted `start` or `reset`.
- Undefined: `mismatch` is constant 0, EXPECT is unused, no comparator logic is synthesized.

## Structure
- Shared header `guia04_defs.vh` holds:
  - the 2-bit state encodings: IDLE=0, DRIVE=1, SAMPLE=2, DONE=3;
  - NVEC=8;
  - the default expected table 8'h54.
- One sub-module: `fxyz_settle_cnt`, a 4-bit load/count-down counter with a `zero` flag, used for the DRIVE dwell.
- FSM, index register and `truth` register live in `fxyz_sweep_ctrl`.

## Test plan
- Reset held 2 cycles, then released with `start`=0 -> all outputs 0 and state IDLE for 20 cycles.
- SETTLE=1, `s` from the real function unit, `start` pulsed at cycle 0:
  - `{x,y,z}` steps 000..111, each held 2 cycles;
  - `done` at cycle 17 only;
  - `truth`=8'h54.
- `start` held high 3 cycles, then pulsed again at cycle 8 -> exactly one sweep, a single `done` at cycle 17, second pulse ignored.
- `reset` at cycle 6 mid-sweep:
  - cycle 7: `busy`=0, `{x,y,z}`=000, `truth`=0;
  - a fresh `start` then completes with `truth`=8'h54.
- Macro defined, `s` driven as ~z -> `truth`=8'h55, `mismatch`=1 after `done`. With the real function unit: `mismatch`=0.
- SETTLE=3 -> each vector held 3 cycles before sampling, `done` at cycle 33, `truth`=8'h54.

Source files
------------

// File: rtl/fxyz_sweep_ctrl_pkg.sv
// Shared definitions for the fxyz truth-table sweep: state encodings, vector count and
// the default expected table for s = (x | y) & ~z.
package fxyz_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned NVec          = 8;
  localparam int unsigned IdxW          = 3;
  localparam logic [7:0]  DefaultExpect = 8'h54;

  // Counter load value so that DRIVE lasts exactly `settle` cycles.
  function automatic logic [3:0] settle_load(input int unsigned settle);
    return 4'(settle - 1);
  endfunction

endpackage

// File: rtl/fxyz_settle_cnt.sv
// 4-bit load/count-down counter with a zero flag; times the DRIVE dwell of each vector.
module fxyz_settle_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/fxyz_sweep_ctrl.sv
// Sweeps {x,y,z} through all 8 vectors and captures s into an 8-bit truth table.
// Optional truth-table checker enabled by defining GUIA04_SWEEP_CHECK_EN.
module fxyz_sweep_ctrl
  import fxyz_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXPECT = DefaultExpect
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       s,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       mismatch
);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NVec-1:0]   truth_q, truth_d;
  logic [2:0]        xyz_q;
  logic              busy_q, done_q;
  logic              cnt_load, cnt_dec, cnt_zero;

  fxyz_settle_cnt u_settle_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (settle_load(SETTLE)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef GUIA04_SWEEP_CHECK_EN
  logic mism_q, mism_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    truth_d  = truth_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef GUIA04_SWEEP_CHECK_EN
    mism_d   = mism_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDrive;
          idx_d    = '0;
          truth_d  = '0;
          cnt_load = 1'b1;
`ifdef GUIA04_SWEEP_CHECK_EN
          mism_d   = 1'b0;
`endif
        end
      end
      StDrive: begin
        if (cnt_zero) begin
          state_d = StSample;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StSample: begin
        truth_d[idx_q] = s;
        if (idx_q == IdxW'(NVec - 1)) begin
          state_d = StDone;
        end else begin
          idx_d    = idx_q + 1'b1;
          state_d  = StDrive;
          cnt_load = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef GUIA04_SWEEP_CHECK_EN
        mism_d  = (truth_q != EXPECT);
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so each registered output matches its cycle's state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      truth_q <= '0;
      xyz_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      truth_q <= truth_d;
      busy_q  <= (state_d == StDrive) || (state_d == StSample);
      done_q  <= (state_d == StDone);
      xyz_q   <= ((state_d == StDrive) || (state_d == StSample)) ? idx_d : 3'b000;
    end
  end

`ifdef GUIA04_SWEEP_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mism_q <= 1'b0;
    end else begin
      mism_q <= mism_d;
    end
  end

  assign mismatch = mism_q;
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT;
  assign mismatch      = 1'b0;
`endif

  assign x     = xyz_q[2];
  assign y     = xyz_q[1];
  assign z     = xyz_q[0];
  assign busy  = busy_q;
  assign done  = done_q;
  assign truth = truth_q;

endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// Scoreboard bench for fxyz_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving a
// behavioural function unit; expected sweeps are queued and checked by a done monitor.
module tb_fxyz_sweep_ctrl;

`ifdef GUIA04_SWEEP_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] truth;
    logic       mism;
  } exp_t;

  logic       clk;
  logic [1:0] rst_v, start_v, bad_v;
  logic [1:0] x_v, y_v, z_v, s_v, busy_v, done_v, mism_v;
  logic [7:0] truth_v [2];
  int         cyc;
  int         n_cmp, n_bad;
  exp_t       exp_q0 [$];
  exp_t       exp_q1 [$];
  logic [1:0] mism_pend;
  logic [1:0] mism_exp;

  fxyz_sweep_ctrl #(.SETTLE(1), .EXPECT(8'h54)) u_dut1 (
    .clk (clk), .reset (rst_v[0]), .start (start_v[0]),
    .x (x_v[0]), .y (y_v[0]), .z (z_v[0]), .s (s_v[0]),
    .busy (busy_v[0]), .done (done_v[0]), .truth (truth_v[0]), .mismatch (mism_v[0])
  );

  fxyz_sweep_ctrl #(.SETTLE(3), .EXPECT(8'h54)) u_dut3 (
    .clk (clk), .reset (rst_v[1]), .start (start_v[1]),
    .x (x_v[1]), .y (y_v[1]), .z (z_v[1]), .s (s_v[1]),
    .busy (busy_v[1]), .done (done_v[1]), .truth (truth_v[1]), .mismatch (mism_v[1])
  );

  // Function unit: real s = (x | y) & ~z, or a faulty ~z when bad_v is set.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      s_v[d] = bad_v[d] ? ~z_v[d] : ((x_v[d] | y_v[d]) & ~z_v[d]);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sp_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Monitor: compares each done pulse (cycle and truth) and the following cycle's mismatch.
  initial mism_pend = 2'b00;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      if (mism_pend[d]) begin
        check("mismatch_after_done", 32'(mism_v[d]), 32'(mism_exp[d]));
        mism_pend[d] = 1'b0;
      end
      if (done_v[d] === 1'b1) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("truth_at_done", 32'(truth_v[d]), 32'(e.truth));
          mism_exp[d]  = e.mism;
          mism_pend[d] = 1'b1;
        end
      end
    end
  end

  // One full sweep started at cycle 0 with per-cycle drive checks.
  task automatic sweep(input int d, input logic bad);
    int   t0;
    int   sp;
    exp_t e;
    sp       = sp_of(d);
    bad_v[d] = bad;
    start_v[d] = 1'b1;
    t0       = cyc;
    e.cyc    = t0 + 8 * sp + 1;
    e.truth  = bad ? 8'h55 : 8'h54;
    e.mism   = CheckEn && (e.truth != 8'h54);
    push_exp(d, e);
    tick();
    start_v[d] = 1'b0;
    for (int c = 1; c <= 8 * sp; c++) begin
      check("busy_xyz_in_sweep", 32'({busy_v[d], x_v[d], y_v[d], z_v[d]}),
            32'({1'b1, 3'((c - 1) / sp)}));
      tick();
    end
    check("busy_xyz_at_done", 32'({busy_v[d], x_v[d], y_v[d], z_v[d]}), 32'd0);
    tick();
    tick();
    check("truth_holds", 32'(truth_v[d]), 32'(e.truth));
    bad_v[d] = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   t0;
    n_cmp   = 0;
    n_bad   = 0;
    rst_v   = 2'b11;
    start_v = 2'b00;
    bad_v   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_v = 2'b00;

    // Idle after reset: everything quiet for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      for (int d = 0; d < 2; d++) begin
        check("idle_outputs",
              32'({busy_v[d], done_v[d], x_v[d], y_v[d], z_v[d], mism_v[d], truth_v[d]}), 32'd0);
      end
      tick();
    end

    sweep(0, 1'b0);

    // start held 3 cycles plus a stray pulse at cycle 8: one sweep only.
    start_v[0] = 1'b1;
    t0 = cyc;
    e.cyc = t0 + 17; e.truth = 8'h54; e.mism = 1'b0;
    push_exp(0, e);
    repeat (3) tick();
    start_v[0] = 1'b0;
    while (cyc < t0 + 8) tick();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    while (cyc < t0 + 20) tick();
    check("idle_after_held_start", 32'({busy_v[0], x_v[0], y_v[0], z_v[0]}), 32'd0);

    // Reset asserted during cycle 6 of a sweep.
    start_v[0] = 1'b1;
    t0 = cyc;
    tick();
    start_v[0] = 1'b0;
    while (cyc < t0 + 6) tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    check("reset_mid_ctrl", 32'({busy_v[0], done_v[0], x_v[0], y_v[0], z_v[0]}), 32'd0);
    check("reset_mid_truth", 32'(truth_v[0]), 32'd0);
    sweep(0, 1'b0);

    // Faulty function unit, then a clean sweep that must clear the checker result.
    sweep(0, 1'b1);
    check("mismatch_held", 32'(mism_v[0]), 32'(CheckEn));
    sweep(0, 1'b0);

    sweep(1, 1'b0);

    repeat (3) tick();
    check("pending_dut1", 32'(exp_q0.size()), 32'd0);
    check("pending_dut3", 32'(exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
